// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: opcodes, PC/writeback select codes,
// ALU operation, FSM state and instruction class encodings.
package multicycle_control_pkg;

  // RV32I base opcodes handled by the controller
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // PC source select
  localparam logic [1:0] CTL_PCSEL_PCPLUS4   = 2'd0;
  localparam logic [1:0] CTL_PCSEL_PCPLUSIMM = 2'd1;
  localparam logic [1:0] CTL_PCSEL_RPLUSIMM  = 2'd2;

  // Writeback select
  localparam logic [2:0] CTL_MTR_ALU  = 3'b000;
  localparam logic [2:0] CTL_MTR_LOAD = 3'b001;
  localparam logic [2:0] CTL_MTR_PC4  = 3'b010;
  localparam logic [2:0] CTL_MTR_IMM  = 3'b011;

  // ALUOP_FUNCT hands the choice to the ALU's own funct3/funct7 decode
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ClsAlu,
    ClsAluImm,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc
  } inst_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_control_if;
  import multicycle_control_pkg::*;

  logic [6:0] inst_opc;
  logic       take_branch;
  logic       mem_ready;

  logic       CTL_RegWrite;
  logic       CTL_AluSrc;
  logic       CTL_BranchEnable;
  logic       CTL_MemRead;
  logic       CTL_MemWrite;
  aluop_t     CTL_AluOp;
  logic [1:0] CTL_PcSel;
  logic [2:0] CTL_MemToReg;
  logic       CTL_PcWrite;
  logic       CTL_IrWrite;
  logic       CTL_Trap;
  logic [2:0] CTL_State;

  // Controller side
  modport master (
    input  inst_opc, take_branch, mem_ready,
    output CTL_RegWrite, CTL_AluSrc, CTL_BranchEnable, CTL_MemRead, CTL_MemWrite,
           CTL_AluOp, CTL_PcSel, CTL_MemToReg, CTL_PcWrite, CTL_IrWrite, CTL_Trap, CTL_State
  );

  // Datapath side
  modport slave (
    output inst_opc, take_branch, mem_ready,
    input  CTL_RegWrite, CTL_AluSrc, CTL_BranchEnable, CTL_MemRead, CTL_MemWrite,
           CTL_AluOp, CTL_PcSel, CTL_MemToReg, CTL_PcWrite, CTL_IrWrite, CTL_Trap, CTL_State
  );
endinterface

// File: rtl/ctl_opc_decode.sv
// Maps a latched opcode to an instruction class; unsupported opcodes clear legal.
module ctl_opc_decode
  import multicycle_control_pkg::*;
(
  input  logic [6:0]  opc,
  output inst_class_t instClass,
  output logic        legal
);

  // Opcode to class lookup
  always_comb begin
    instClass = ClsAlu;
    legal     = 1'b1;
    case (opc)
      OPC_OP:     instClass = ClsAlu;
      OPC_OPIMM:  instClass = ClsAluImm;
      OPC_LOAD:   instClass = ClsLoad;
      OPC_STORE:  instClass = ClsStore;
      OPC_BRANCH: instClass = ClsBranch;
      OPC_JAL:    instClass = ClsJal;
      OPC_JALR:   instClass = ClsJalr;
      OPC_LUI:    instClass = ClsLui;
      OPC_AUIPC:  instClass = ClsAuipc;
      default:    legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on
// illegal opcodes or memory handshake timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TIMEOUT_W   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t                 state;
  state_t                 stateNext;
  logic [6:0]             opcQ;
  logic [TIMEOUT_W-1:0]   waitCnt;
  inst_class_t            cls;
  logic                   legal;
  logic                   timedOut;
  logic                   memDone;

  ctl_opc_decode u_decode (
    .opc       (opcQ),
    .instClass (cls),
    .legal     (legal)
  );

  // A ready arriving in the timeout cycle is ignored, so no strobe may act on it.
  assign timedOut = (MEM_TIMEOUT != 0) && (waitCnt == TIMEOUT_W'(MEM_TIMEOUT));
  assign memDone  = bus.mem_ready && !timedOut;

  // Next-state selection
  always_comb begin
    stateNext = state;
    case (state)
      StFetch: begin
        if (timedOut)     stateNext = StTrap;
        else if (memDone) stateNext = StDecode;
      end
      StDecode: stateNext = legal ? StExec : StTrap;
      StExec: begin
        case (cls)
          ClsLoad, ClsStore: stateNext = StMem;
          ClsBranch:         stateNext = StFetch;
          default:           stateNext = StWb;
        endcase
      end
      StMem: begin
        if (timedOut)     stateNext = StTrap;
        else if (memDone) stateNext = (cls == ClsLoad) ? StWb : StFetch;
      end
      StWb:    stateNext = StFetch;
      StTrap:  stateNext = StTrap;
      default: stateNext = StTrap;
    endcase
  end

  // State, opcode latch and saturating wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= StFetch;
      opcQ    <= '0;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == StFetch && memDone) begin
        opcQ <= bus.inst_opc;
      end
      if (stateNext != state) begin
        waitCnt <= '0;
      end else if ((state == StFetch || state == StMem) && !bus.mem_ready &&
                   (waitCnt != '1)) begin
        waitCnt <= waitCnt + TIMEOUT_W'(1);
      end
    end
  end

  // Datapath strobes decoded from state, class and handshake inputs
  always_comb begin
    bus.CTL_RegWrite     = 1'b0;
    bus.CTL_AluSrc       = 1'b0;
    bus.CTL_BranchEnable = 1'b0;
    bus.CTL_MemRead      = 1'b0;
    bus.CTL_MemWrite     = 1'b0;
    bus.CTL_AluOp        = ALUOP_ADD;
    bus.CTL_PcSel        = CTL_PCSEL_PCPLUS4;
    bus.CTL_MemToReg     = CTL_MTR_ALU;
    bus.CTL_PcWrite      = 1'b0;
    bus.CTL_IrWrite      = 1'b0;
    case (state)
      StFetch: begin
        bus.CTL_MemRead = 1'b1;
        bus.CTL_IrWrite = memDone;
      end
      StExec: begin
        bus.CTL_AluSrc = cls inside {ClsAluImm, ClsLoad, ClsStore, ClsJalr, ClsLui, ClsAuipc};
        case (cls)
          ClsLoad, ClsStore, ClsJal, ClsJalr, ClsAuipc: bus.CTL_AluOp = ALUOP_ADD;
          ClsBranch:                                    bus.CTL_AluOp = ALUOP_SUB;
          default:                                      bus.CTL_AluOp = ALUOP_FUNCT;
        endcase
        if (cls == ClsBranch) begin
          bus.CTL_BranchEnable = 1'b1;
          bus.CTL_PcWrite      = 1'b1;
          bus.CTL_PcSel        = bus.take_branch ? CTL_PCSEL_PCPLUSIMM : CTL_PCSEL_PCPLUS4;
        end
      end
      StMem: begin
        bus.CTL_MemRead  = (cls == ClsLoad);
        bus.CTL_MemWrite = (cls == ClsStore);
        bus.CTL_PcWrite  = (cls == ClsStore) && memDone;
      end
      StWb: begin
        bus.CTL_RegWrite = 1'b1;
        bus.CTL_PcWrite  = 1'b1;
        case (cls)
          ClsJal:  bus.CTL_PcSel = CTL_PCSEL_PCPLUSIMM;
          ClsJalr: bus.CTL_PcSel = CTL_PCSEL_RPLUSIMM;
          default: bus.CTL_PcSel = CTL_PCSEL_PCPLUS4;
        endcase
        case (cls)
          ClsLoad:         bus.CTL_MemToReg = CTL_MTR_LOAD;
          ClsJal, ClsJalr: bus.CTL_MemToReg = CTL_MTR_PC4;
          ClsLui:          bus.CTL_MemToReg = CTL_MTR_IMM;
          default:         bus.CTL_MemToReg = CTL_MTR_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.CTL_Trap  = (state == StTrap);
  assign bus.CTL_State = state;

endmodule
